// File: rtl/alu_ctrl_seq.sv
// ALU control decoder with a sequential shift-add multiplier / restoring divider.
// Define ALU_MD_SIGNED_EN for two's-complement mult/div; the default build is unsigned.
module alu_ctrl_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [3:0]       alu_ctrl,
  output logic             ctrl_valid,
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   acc_hi, acc_lo, mcand;
  logic               accept, is_mul, is_div, last;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   mul_hi_nx, mul_lo_nx, div_rem_nx, div_quo_nx;
  logic [2*WIDTH-1:0] prod_fin;
  logic [WIDTH-1:0]   quo_fin, rem_fin, dz_hi, a_mag, b_mag;

  function automatic logic [3:0] decode(input logic [1:0] op, input logic [5:0] fn);
    logic [3:0] code;
    code = 4'b0000;
    case (op)
      2'b00: code = 4'b0010;
      2'b01: code = 4'b0110;
      2'b10: begin
        case (fn)
          6'b100100: code = 4'b0000;
          6'b100101: code = 4'b0001;
          6'b100000: code = 4'b0010;
          6'b100110: code = 4'b0100;
          6'b011000: code = 4'b0101;
          6'b100010: code = 4'b0110;
          6'b101010: code = 4'b0111;
          6'b000000: code = 4'b1000;
          6'b000010: code = 4'b1001;
          6'b000011: code = 4'b1010;
          6'b011010: code = 4'b1011;
          6'b100111: code = 4'b1100;
          default:   code = 4'b0000;
        endcase
      end
      default: code = 4'b0000;
    endcase
    return code;
  endfunction

  assign md_busy  = (state != IDLE);
  assign md_done  = (state == DONE);
  assign in_ready = !md_busy;
  assign accept   = in_valid && in_ready;
  assign is_mul   = (alu_op == 2'b10) && (funct == 6'b011000);
  assign is_div   = (alu_op == 2'b10) && (funct == 6'b011010);
  assign last     = (count == CW'(1));

  // One shift-add step: acc_hi is the running upper half, acc_lo the remaining multiplier bits.
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
  assign mul_hi_nx = mul_sum[WIDTH:1];
  assign mul_lo_nx = {mul_sum[0], acc_lo[WIDTH-1:1]};

  // One restoring step: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  assign div_shift  = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff   = div_shift - {1'b0, mcand};
  assign div_ge     = (div_shift >= {1'b0, mcand});
  assign div_rem_nx = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_quo_nx = {acc_lo[WIDTH-2:0], div_ge};

`ifdef ALU_MD_SIGNED_EN
  logic neg_q, neg_r;

  assign a_mag    = op_a[WIDTH-1] ? -op_a : op_a;
  assign b_mag    = op_b[WIDTH-1] ? -op_b : op_b;
  assign prod_fin = neg_q ? -{mul_hi_nx, mul_lo_nx} : {mul_hi_nx, mul_lo_nx};
  assign quo_fin  = neg_q ? -div_quo_nx : div_quo_nx;
  assign rem_fin  = neg_r ? -div_rem_nx : div_rem_nx;
  assign dz_hi    = neg_r ? -acc_lo : acc_lo;

  // Result sign flags captured with the operands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept && (is_mul || is_div)) begin
      neg_q <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
      neg_r <= op_a[WIDTH-1];
    end else begin
      neg_q <= neg_q;
      neg_r <= neg_r;
    end
  end
`else
  assign a_mag    = op_a;
  assign b_mag    = op_b;
  assign prod_fin = {mul_hi_nx, mul_lo_nx};
  assign quo_fin  = div_quo_nx;
  assign rem_fin  = div_rem_nx;
  assign dz_hi    = acc_lo;
`endif

  // Engine next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && is_mul)      state_next = MUL;
        else if (accept && is_div) state_next = DIV;
        else                       state_next = IDLE;
      end
      MUL:     state_next = last ? DONE : MUL;
      DIV:     state_next = (last || (mcand == {WIDTH{1'b0}})) ? DONE : DIV;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, decode output and mult/div datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      alu_ctrl   <= 4'b0000;
      ctrl_valid <= 1'b0;
      count      <= {CW{1'b0}};
      acc_hi     <= {WIDTH{1'b0}};
      acc_lo     <= {WIDTH{1'b0}};
      mcand      <= {WIDTH{1'b0}};
      hi         <= {WIDTH{1'b0}};
      lo         <= {WIDTH{1'b0}};
    end else begin
      state      <= state_next;
      ctrl_valid <= accept;
      if (accept) alu_ctrl <= decode(alu_op, funct);
      else        alu_ctrl <= alu_ctrl;
      case (state)
        IDLE: begin
          if (accept && (is_mul || is_div)) begin
            count  <= CW'(WIDTH);
            acc_hi <= {WIDTH{1'b0}};
            acc_lo <= a_mag;
            mcand  <= b_mag;
          end
        end
        MUL: begin
          acc_hi <= mul_hi_nx;
          acc_lo <= mul_lo_nx;
          count  <= count - CW'(1);
          if (last) {hi, lo} <= prod_fin;
        end
        DIV: begin
          if (mcand == {WIDTH{1'b0}}) begin
            count <= {CW{1'b0}};
            hi    <= dz_hi;
            lo    <= {WIDTH{1'b1}};
          end else begin
            acc_hi <= div_rem_nx;
            acc_lo <= div_quo_nx;
            count  <= count - CW'(1);
            if (last) begin
              hi <= rem_fin;
              lo <= quo_fin;
            end
          end
        end
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand and HI/LO width; legal values are even and 8..64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  op presented.
REQ-005 SHALL have port in_ready  output  1  op can be accepted this cycle.
REQ-006 SHALL have port alu_op  input  2  main-decoder op class.
REQ-007 SHALL have port funct  input  6  R-type function field.
REQ-008 SHALL have port op_a, op_b  input  WIDTH  operands, used for mult/div only.
REQ-009 SHALL have port alu_ctrl  output  4  registered ALU control code.
REQ-010 SHALL have port ctrl_valid  output  1  alu_ctrl holds a newly accepted op this cycle.
REQ-011 SHALL have port md_busy  output  1  mult/div engine active.
REQ-012 SHALL have port md_done  output  1  one-cycle pulse; hi/lo just updated.
REQ-013 SHALL have port hi, lo  output  WIDTH  mult/div result registers.

Function
REQ-014 SHALL accept an op on a rising edge when in_valid and in_ready are both high.
REQ-015 SHALL register the decode at the accept edge, giving 1-cycle latency; ctrl_valid SHALL be high exactly in the following cycle.
REQ-016 SHALL decode alu_op 00 to 0010 (add), 01 to 0110 (sub), and 11 to 0000 (and).
REQ-017 SHALL decode alu_op 10 from funct: 100100->0000, 100101->0001, 100000->0010, 100110->0100, 011000->0101 (mult), 100010->0110, 101010->0111, 000000->1000, 000010->1001, 000011->1010, 011010->1011 (div), 100111->1100; any other funct SHALL decode to 0000.
REQ-018 SHALL run engine states IDLE, MUL, DIV and DONE.
REQ-019 SHALL, when a mult is accepted, latch the operands and go IDLE->MUL; when a div is accepted, go IDLE->DIV.
REQ-020 SHALL perform one shift-add or restoring-subtract iteration per cycle in MUL/DIV, for exactly WIDTH iterations counted by a down-counter, then move to DONE.
REQ-021 SHALL write hi/lo on the edge that enters DONE: mult gives {hi,lo} = 2*WIDTH-bit product; div gives lo = quotient and hi = remainder.
REQ-022 SHALL assert md_done only in DONE and then return to IDLE on the next edge; md_done therefore occurs WIDTH+1 cycles after the accept edge.
REQ-023 SHALL, for div with op_b == 0, go DIV->DONE in one cycle with lo = all ones and hi = op_a; mult/div SHALL never be stalled by divide-by-zero.
REQ-024 SHALL drive md_busy high in MUL, DIV and DONE, and SHALL drive in_ready = !md_busy.
REQ-025 SHALL leave hi/lo unchanged by non-mult/div ops; outside DONE, hi/lo hold their values.
REQ-026 SHALL ignore in_valid while in_ready is low, so no op is lost or duplicated; the upstream stage holds the op.

Reset
REQ-027 SHALL, at a rising edge with rst_n low, set alu_ctrl=0000, ctrl_valid=0, md_busy=0, md_done=0, hi=0, lo=0, the counter to 0 and the state to IDLE.
REQ-028 SHALL abort any mult/div in progress on reset, without writing a partial result; in_ready SHALL be 1 in the first cycle after reset.

Configuration
REQ-029 SHALL, with macro ALU_MD_SIGNED_EN defined, treat mult/div operands as two's complement using a magnitude core plus sign fix-up that adds no cycles: product negated if the signs differ; quotient negated if the signs differ; remainder takes the sign of op_a.
REQ-030 SHALL, without ALU_MD_SIGNED_EN, treat operands as unsigned and omit the sign-correction logic.

Verification
REQ-031 SHALL cover decode sweep: all four alu_op values plus every listed funct and funct 111111 -> codes per REQ-016/017, each one cycle after accept, and 111111 -> 0000.
REQ-032 SHALL cover mult, WIDTH=32: op_a=0x0001_0000, op_b=0x0003_0000 -> md_done at cycle 33, hi=0x0000_0003, lo=0; in_ready low for cycles 1..33.
REQ-033 SHALL cover div: 100 / 7 -> lo=14, hi=2; with ALU_MD_SIGNED_EN, -100 / 7 -> lo=0xFFFF_FFF2, hi=0xFFFF_FFFE.
REQ-034 SHALL cover divide by zero: op_a=0x1234, op_b=0 -> md_done 2 cycles after accept, lo=0xFFFF_FFFF, hi=0x1234.
REQ-035 SHALL cover back-pressure: add held with in_valid=1 during a mult -> accepted only in the cycle after md_done; hi/lo unchanged by the add.
REQ-036 SHALL cover reset mid-op: rst_n low at cycle 10 of a mult -> next cycle state IDLE, hi=lo=0, md_done never pulses, in_ready=1.
